// File: rtl/Noc_parameters.sv
// Shared NoC router parameters and scheduler state encoding.
package Noc_parameters;

  localparam int Noc_VC_Channel = 4;
  localparam int Noc_Flit_Width = 32;
  localparam int Noc_VC_Credits = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module noc_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_next_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // scan from the pointer with wrap and stop at the first request
  always_comb begin
    grant      = '0;
    ptr_next_s = ptr_r;
    found_s    = 1'b0;
    idx_s      = '0;
    for (int i = 0; i < N; i++) begin
      idx_s = PW'((int'(ptr_r) + i) % N);
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        ptr_next_s   = (idx_s == PW'(N - 1)) ? '0 : idx_s + PW'(1);
      end else begin
        found_s = found_s;
      end
    end
  end

  // pointer moves past the winner only when the grant is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (clear) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/noc_vc_output_scheduler.sv
// Credit-based output scheduler: round-robin over VC FIFOs onto one link,
// with per-VC downstream credits and optional packet locking.
module noc_vc_output_scheduler
  import Noc_parameters::*;
#(
  parameter int CHANNELS    = Noc_VC_Channel,
  parameter int FLIT_WIDTH  = Noc_Flit_Width,
  parameter int CREDITS     = Noc_VC_Credits,
  parameter bit LOCK_PACKET = 1'b0
) (
  input  logic                                noc_clk,
  input  logic                                noc_rst,
  input  logic                                i_clear,
  input  logic [CHANNELS-1:0]                 i_vc_valid,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] i_vc_flit,
  input  logic [CHANNELS-1:0]                 i_vc_tail,
  output logic [CHANNELS-1:0]                 o_vc_pop,
  output logic                                o_valid,
  output logic [CHANNELS-1:0]                 o_vc,
  output logic [FLIT_WIDTH-1:0]               o_flit,
  input  logic [CHANNELS-1:0]                 i_credit,
  output logic [CHANNELS-1:0]                 o_credit_avail,
  output logic                                o_credit_error
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int VW = $clog2(CHANNELS);

  logic [CW-1:0]         credit_r [CHANNELS];
  sched_state_e          state_r;
  sched_state_e          state_next_s;
  logic [VW-1:0]         lock_vc_r;
  logic [VW-1:0]         lock_vc_next_s;
  logic [VW-1:0]         grant_idx_s;
  logic [CHANNELS-1:0]   elig_s;
  logic [CHANNELS-1:0]   avail_s;
  logic [CHANNELS-1:0]   req_s;
  logic [CHANNELS-1:0]   grant_s;
  logic                  any_grant_s;
  logic                  grant_tail_s;
  logic [FLIT_WIDTH-1:0] grant_flit_s;
  logic                  valid_r;
  logic [CHANNELS-1:0]   vc_r;
  logic [FLIT_WIDTH-1:0] flit_r;
  logic                  error_r;

  // eligibility, with requests masked to the owner while a packet holds the link
  always_comb begin
    elig_s  = '0;
    avail_s = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      avail_s[v] = (credit_r[v] != '0);
      elig_s[v]  = i_vc_valid[v] & avail_s[v];
    end
    if (noc_rst || i_clear) begin
      req_s = '0;
    end else if (LOCK_PACKET && (state_r == LOCKED)) begin
      req_s = elig_s & (CHANNELS'(1) << lock_vc_r);
    end else begin
      req_s = elig_s;
    end
  end

  noc_rr_arbiter #(.N(CHANNELS)) u_arb (
    .clk     (noc_clk),
    .rst     (noc_rst),
    .clear   (i_clear),
    .req     (req_s),
    .advance (any_grant_s),
    .grant   (grant_s)
  );

  // one-hot grant to index, flit and tail via AND-OR muxing
  always_comb begin
    grant_idx_s  = '0;
    grant_flit_s = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      grant_idx_s  = grant_idx_s | (VW'(v) & {VW{grant_s[v]}});
      grant_flit_s = grant_flit_s | (i_vc_flit[v] & {FLIT_WIDTH{grant_s[v]}});
    end
    any_grant_s  = |grant_s;
    grant_tail_s = |(grant_s & i_vc_tail);
  end

  // packet lock next-state
  always_comb begin
    state_next_s   = state_r;
    lock_vc_next_s = lock_vc_r;
    case (state_r)
      IDLE: begin
        if (LOCK_PACKET && any_grant_s && !grant_tail_s) begin
          state_next_s   = LOCKED;
          lock_vc_next_s = grant_idx_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCKED: begin
        if (any_grant_s && grant_tail_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // packet lock state register
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_r   <= IDLE;
      lock_vc_r <= '0;
    end else if (i_clear) begin
      state_r   <= IDLE;
      lock_vc_r <= '0;
    end else begin
      state_r   <= state_next_s;
      lock_vc_r <= lock_vc_next_s;
    end
  end

  // credit counters; a return at full count is held and flagged, never wrapped
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      for (int v = 0; v < CHANNELS; v++) credit_r[v] <= CW'(CREDITS);
      error_r <= 1'b0;
    end else if (i_clear) begin
      for (int v = 0; v < CHANNELS; v++) credit_r[v] <= CW'(CREDITS);
      error_r <= 1'b0;
    end else begin
      for (int v = 0; v < CHANNELS; v++) begin
        case ({grant_s[v], i_credit[v]})
          2'b01: begin
            if (credit_r[v] == CW'(CREDITS)) begin
              error_r <= 1'b1;
            end else begin
              credit_r[v] <= credit_r[v] + CW'(1);
            end
          end
          2'b10:   credit_r[v] <= credit_r[v] - CW'(1);
          default: credit_r[v] <= credit_r[v];
        endcase
      end
    end
  end

  // link register; tag and flit hold across idle cycles
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      valid_r <= 1'b0;
      vc_r    <= '0;
      flit_r  <= '0;
    end else if (i_clear) begin
      valid_r <= 1'b0;
      vc_r    <= '0;
      flit_r  <= '0;
    end else begin
      valid_r <= any_grant_s;
      if (any_grant_s) begin
        vc_r   <= grant_s;
        flit_r <= grant_flit_s;
      end
    end
  end

  assign o_vc_pop       = grant_s;
  assign o_valid        = valid_r;
  assign o_vc           = vc_r;
  assign o_flit         = flit_r;
  assign o_credit_avail = avail_s;
  assign o_credit_error = error_r;

endmodule
